// File: rtl/reg_read_arb_pkg.sv
// Shared types and sizes for the register-file read arbiter.
package reg_read_arb_pkg;

    localparam int NREGS  = 8;
    localparam int ADDR_W = $clog2(NREGS);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/reg_read_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last_gnt+1 upward with wrap.
// Optional build macro REG_READ_ARB_PRIO0_EN gives requester 0 absolute priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_gnt,
    output logic            found,
    output logic [GW-1:0]   winner
);

    logic [NREQ-1:0] cand;
    int              idx;

    always_comb begin
        cand   = req;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
`ifdef REG_READ_ARB_PRIO0_EN
        // Requester 0 overrides; the rest rotate among themselves only.
        if (req[0]) begin
            found = 1'b1;
        end
        cand[0] = 1'b0;
`endif
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_gnt) + i) % NREQ;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NREQ clients.
// Build macro REG_READ_ARB_PRIO0_EN makes requester 0 (control unit) always win.
module reg_read_arbiter
    import reg_read_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   rdata_valid,
    output logic [GW-1:0]          gnt_id,
    output logic                   busy,
    output logic [ADDR_W-1:0]      mux_adres,
    input  logic [DATA_W-1:0]      mux_out
);

    state_e              state_q, state_d;
    logic [GW-1:0]       gnt_id_q, gnt_id_d;
    logic [GW-1:0]       last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                rdata_valid_q, rdata_valid_d;

    logic                pick_found;
    logic [GW-1:0]       pick_winner;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .found    (pick_found),
        .winner   (pick_winner)
    );

    always_comb begin
        state_d       = state_q;
        gnt_id_d      = gnt_id_q;
        last_gnt_d    = last_gnt_q;
        addr_d        = addr_q;
        rdata_d       = rdata_q;
        ack_d         = '0;
        rdata_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Address is sampled only here; later req_addr changes are ignored.
                if (pick_found) begin
                    gnt_id_d = pick_winner;
                    addr_d   = req_addr[pick_winner*ADDR_W +: ADDR_W];
                    state_d  = SEL;
                end
            end
            SEL: begin
                rdata_d       = mux_out;
                ack_d         = NREQ'(1) << gnt_id_q;
                rdata_valid_d = 1'b1;
                state_d       = ACK;
            end
            ACK: begin
`ifdef REG_READ_ARB_PRIO0_EN
                if (gnt_id_q != '0) begin
                    last_gnt_d = gnt_id_q;
                end
`else
                last_gnt_d = gnt_id_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_id_q      <= '0;
            last_gnt_q    <= GW'(NREQ - 1);
            addr_q        <= '0;
            rdata_q       <= '0;
            ack_q         <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_id_q      <= gnt_id_d;
            last_gnt_q    <= last_gnt_d;
            addr_q        <= addr_d;
            rdata_q       <= rdata_d;
            ack_q         <= ack_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign gnt_id      = gnt_id_q;
    assign mux_adres   = addr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter with a behavioural register file on the mux.
// Expected values follow REG_READ_ARB_PRIO0_EN when it is defined.
module tb_reg_read_arbiter;

    localparam int NREQ = 4;
    localparam int GW   = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   ack;
    logic [7:0]        rdata;
    logic              rdata_valid;
    logic [GW-1:0]     gnt_id;
    logic              busy;
    logic [2:0]        mux_adres;
    logic [7:0]        mux_out;

    logic [7:0]        regs [8];

    int n_total = 0;
    int n_bad   = 0;

    reg_read_arbiter #(.NREQ(NREQ), .GW(GW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .ack         (ack),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .mux_adres   (mux_adres),
        .mux_out     (mux_out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    assign mux_out = regs[mux_adres];

    // scoreboard check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [2:0] a);
        req_addr[i*3 +: 3] = a;
    endtask

    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (ack == '0 && cycles < 10);
        if (ack == '0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] fair_data [4];
    logic [3:0] hold_ack  [3];
    int         cyc;

    initial begin
        fair_data[0] = 8'd10; fair_data[1] = 8'd20;
        fair_data[2] = 8'd30; fair_data[3] = 8'd40;
`ifdef REG_READ_ARB_PRIO0_EN
        hold_ack[0] = 4'b0001; hold_ack[1] = 4'b0001; hold_ack[2] = 4'b0001;
`else
        hold_ack[0] = 4'b0001; hold_ack[1] = 4'b0010; hold_ack[2] = 4'b0001;
`endif
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        regs[0] = 8'd10; regs[1] = 8'd20; regs[2] = 8'd30; regs[3] = 8'd40;
        regs[5] = 8'hA7; regs[6] = 8'h5C;

        // reset with all requests pending
        rst = 1'b1;
        req = 4'b1111;
        req_addr = '0;
        for (int i = 0; i < NREQ; i++) set_addr(i, 3'(i));
        tick();
        tick();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rvalid", 32'(rdata_valid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_gnt", 32'(gnt_id), 32'h0);
        chk("rst_mux", 32'(mux_adres), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        rst = 1'b0;
        tick();
        chk("first_noack", 32'(ack), 32'h0);
        chk("first_busy", 32'(busy), 32'h1);
        chk("first_gnt", 32'(gnt_id), 32'h0);

        // fairness: rotation 0..3, each drops on its ack
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc);
            chk("fair_ack", 32'(ack), 32'(4'b0001 << k));
            chk("fair_rdata", 32'(rdata), 32'(fair_data[k]));
            chk("fair_gnt", 32'(gnt_id), 32'(k));
            chk("fair_space", 32'(cyc), (k == 0) ? 32'd1 : 32'd3);
            req[k] = 1'b0;
        end
        tick();
        chk("fair_idle", 32'(busy), 32'h0);

        // single read from R5 by requester 2
        set_addr(2, 3'd5);
        req = 4'b0100;
        tick();
        chk("single_gnt", 32'(gnt_id), 32'h2);
        chk("single_mux", 32'(mux_adres), 32'h5);
        chk("single_noack", 32'(ack), 32'h0);
        tick();
        chk("single_ack", 32'(ack), 32'b0100);
        chk("single_rdata", 32'(rdata), 32'hA7);
        chk("single_rvalid", 32'(rdata_valid), 32'h1);
        req = 4'b0000;
        tick();
        chk("single_ackoff", 32'(ack), 32'h0);
        chk("single_rvoff", 32'(rdata_valid), 32'h0);
        chk("single_hold", 32'(rdata), 32'hA7);

        // make requester 3 last served, then 0 and 3 together
        req = 4'b1000;
        wait_ack(cyc);
        chk("lone3_ack", 32'(ack), 32'b1000);
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        chk("wrap_gnt0", 32'(gnt_id), 32'h0);
        tick();
        chk("wrap_ack0", 32'(ack), 32'b0001);
        req[0] = 1'b0;
        tick();
        tick();
        chk("wrap_gnt3", 32'(gnt_id), 32'h3);
        tick();
        chk("wrap_ack3", 32'(ack), 32'b1000);
        req = 4'b0000;
        tick();

        // req 0 and 1 held continuously
        req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            wait_ack(cyc);
            chk("hold_ack", 32'(ack), 32'(hold_ack[k]));
            chk("hold_space", 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
        end
        req = 4'b0000;
        tick();

        // address change during SEL has no effect
        set_addr(2, 3'd5);
        req = 4'b0100;
        tick();
        set_addr(2, 3'd6);
        tick();
        chk("addrchg_ack", 32'(ack), 32'b0100);
        chk("addrchg_rdata", 32'(rdata), 32'hA7);
        chk("addrchg_mux", 32'(mux_adres), 32'h5);
        req = 4'b0000;
        tick();

        // dropping req in SEL still completes
        set_addr(1, 3'd1);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        chk("abort_ack", 32'(ack), 32'b0010);
        chk("abort_rdata", 32'(rdata), 32'd20);
        tick();

        // reset during SEL
        set_addr(0, 3'd6);
        req = 4'b0001;
        tick();
        chk("midrst_busy", 32'(busy), 32'h1);
        chk("midrst_mux", 32'(mux_adres), 32'h6);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_rvalid", 32'(rdata_valid), 32'h0);
        chk("midrst_idle", 32'(busy), 32'h0);
        chk("midrst_rdata", 32'(rdata), 32'h0);
        rst = 1'b0;
        tick();
        chk("midrst_noack", 32'(ack), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
